// File: rtl/sram_link_pkg.sv
// Shared definitions for the SRAM subsystem command link: command codes,
// special response words, response status codes and the initiator FSM states.
package sram_link_pkg;

    // Command codes carried on the offer channel; codes above CMD_WR are illegal.
    localparam logic [3:0] CMD_PWR_OFF = 4'd0;
    localparam logic [3:0] CMD_PWR_ON  = 4'd1;
    localparam logic [3:0] CMD_RD      = 4'd2;
    localparam logic [3:0] CMD_WR      = 4'd3;

    // Response words with a fixed meaning.
    localparam logic [15:0] NAK_WORD = 16'h000D;
    localparam logic [15:0] ACK_WORD = 16'h0001;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_NAK     = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_WAIT = 3'd4,
        ST_RESP = 3'd5
    } state_e;

endpackage

// File: rtl/sram_client_initiator.sv
// Client-side initiator for the SRAM subsystem command link.
// Takes one host request at a time, sends the command on offer, the address
// (and write data) on receive, then waits for the controller's response word
// on send and hands status plus data back to the host. Tracks whether the
// subsystem is powered so memory commands can be refused locally.
// Optional feature: define SRAM_CLIENT_TIMEOUT_EN to bound the response wait
// to TIMEOUT_CYCLES cycles (status TIMEOUT on expiry).
module sram_client_initiator
    import sram_link_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int CMD_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic [CMD_W-1:0]  offer,
    output logic              offer_valid,
    input  logic              offer_ready,
    output logic [DATA_W-1:0] receive,
    output logic              dfcq_valid,
    input  logic              dfcq_ready,
    input  logic [DATA_W-1:0] send,
    input  logic              send_valid,
    output logic              powered,
    output logic [2:0]        current_state
);

    // A wait limit of zero cycles has no meaning; stop elaboration early.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sram_client_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_reg, state_next;
    logic [CMD_W-1:0]  cmd_reg, cmd_next;
    logic [DATA_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    rsp_status_e       rsp_status_reg, rsp_status_next;
    logic              powered_reg, powered_next;

    // Command decode: incoming request (used at accept) and latched command.
    logic req_is_legal, req_is_mem;
    logic cmd_is_wr, cmd_is_mem, cmd_is_pwr_on, cmd_is_pwr_off;
    logic send_is_nak;

    assign req_is_legal   = (req_cmd <= CMD_W'(CMD_WR));
    assign req_is_mem     = (req_cmd == CMD_W'(CMD_RD)) || (req_cmd == CMD_W'(CMD_WR));
    assign cmd_is_wr      = (cmd_reg == CMD_W'(CMD_WR));
    assign cmd_is_mem     = (cmd_reg == CMD_W'(CMD_RD)) || cmd_is_wr;
    assign cmd_is_pwr_on  = (cmd_reg == CMD_W'(CMD_PWR_ON));
    assign cmd_is_pwr_off = (cmd_reg == CMD_W'(CMD_PWR_OFF));
    assign send_is_nak    = (send == DATA_W'(NAK_WORD));

`ifdef SRAM_CLIENT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             wait_expired;

    // Counter restarts from zero on every WAIT entry and advances each WAIT cycle.
    always_comb begin
        wait_cnt_next = '0;
        if (state_reg == ST_WAIT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    // Expiry cycle is the TIMEOUT_CYCLES-th cycle spent in WAIT.
    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    // Next-state and datapath-latch logic for the request sequence.
    always_comb begin
        state_next      = state_reg;
        cmd_next        = cmd_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_status_next = rsp_status_reg;
        powered_next    = powered_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    cmd_next  = req_cmd;
                    addr_next = req_addr;
                    data_next = req_data;
                    // Illegal commands and memory access to an unpowered
                    // subsystem are answered locally without touching the link.
                    if (!req_is_legal || (req_is_mem && !powered_reg)) begin
                        state_next      = ST_RESP;
                        rsp_status_next = RSP_NAK;
                        rsp_data_next   = DATA_W'(NAK_WORD);
                    end else begin
                        state_next = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (offer_ready) begin
                    state_next = cmd_is_mem ? ST_ADDR : ST_WAIT;
                end
            end
            ST_ADDR: begin
                if (dfcq_ready) begin
                    state_next = cmd_is_wr ? ST_DATA : ST_WAIT;
                end
            end
            ST_DATA: begin
                if (dfcq_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (send_valid) begin
                    state_next    = ST_RESP;
                    rsp_data_next = send;
                    if (send_is_nak) begin
                        rsp_status_next = RSP_NAK;
                    end else begin
                        rsp_status_next = RSP_OK;
                        if (cmd_is_pwr_on) begin
                            powered_next = 1'b1;
                        end else if (cmd_is_pwr_off) begin
                            powered_next = 1'b0;
                        end
                    end
                end
`ifdef SRAM_CLIENT_TIMEOUT_EN
                else if (wait_expired) begin
                    state_next      = ST_RESP;
                    rsp_status_next = RSP_TIMEOUT;
                    rsp_data_next   = '0;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and latched request/response registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg      <= ST_IDLE;
            cmd_reg        <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            rsp_data_reg   <= '0;
            rsp_status_reg <= RSP_OK;
            powered_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cmd_reg        <= cmd_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_status_reg <= rsp_status_next;
            powered_reg    <= powered_next;
        end
    end

    // Handshake outputs decode straight from the state; payloads are zero when idle.
    assign req_ready     = (state_reg == ST_IDLE);
    assign rsp_valid     = (state_reg == ST_RESP);
    assign offer_valid   = (state_reg == ST_CMD);
    assign offer         = offer_valid ? cmd_reg : '0;
    assign dfcq_valid    = (state_reg == ST_ADDR) || (state_reg == ST_DATA);
    assign receive       = (state_reg == ST_ADDR) ? addr_reg :
                           (state_reg == ST_DATA) ? data_reg : '0;
    assign rsp_data      = rsp_data_reg;
    assign rsp_status    = rsp_status_reg;
    assign powered       = powered_reg;
    assign current_state = state_reg;

endmodule

// File: tb/tb_sram_client_initiator.sv
// Self-checking bench for sram_client_initiator. The bench plays both host and
// SRAM controller; a transaction-level model predicts link traffic, response,
// power state and latency from the command rules.
module tb_sram_client_initiator;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int TO = 8;
`ifdef SRAM_CLIENT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_cmd;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic [CW-1:0] offer;
    logic          offer_valid;
    logic          offer_ready;
    logic [DW-1:0] receive;
    logic          dfcq_valid;
    logic          dfcq_ready;
    logic [DW-1:0] send;
    logic          send_valid;
    logic          powered;
    logic [2:0]    current_state;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;
    bit model_powered = 1'b0;

    always #5 CLK = ~CLK;

    sram_client_initiator #(
        .DATA_W(DW), .CMD_W(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .offer(offer), .offer_valid(offer_valid), .offer_ready(offer_ready),
        .receive(receive), .dfcq_valid(dfcq_valid), .dfcq_ready(dfcq_ready),
        .send(send), .send_valid(send_valid),
        .powered(powered), .current_state(current_state)
    );

    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One full host transaction with the bench acting as controller.
    // send_delay counts WAIT cycles before the response pulse (0 = first cycle).
    task automatic do_txn(input logic [3:0] cmd, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] send_word,
                          input int send_delay, input bit rnd_stall,
                          input int addr_hold, input int rsp_hold, input string name);
        logic [15:0] exp_words[$];
        logic [15:0] got_words[$];
        logic [3:0]  got_offers[$];
        bit          local_rej, timed_out, in_wait, seen;
        logic [1:0]  exp_status;
        logic [15:0] exp_data;
        bit          exp_pwr;
        int          exp_lat, hs, stalls, cyc, wait_cyc, addr_left, bad_idle, bad_order, bad_hold;
        bit          offers_ok, words_ok;

        // Transaction-level prediction.
        local_rej = (cmd > 4'd3) || ((cmd == 4'd2 || cmd == 4'd3) && !model_powered);
        if (cmd == 4'd2 || cmd == 4'd3) exp_words.push_back(addr);
        if (cmd == 4'd3) exp_words.push_back(wdata);
        timed_out = !local_rej && TO_EN && (send_delay >= TO);
        exp_pwr   = model_powered;
        if (local_rej) begin
            exp_status = 2'd1; exp_data = 16'h000D;
        end else if (timed_out) begin
            exp_status = 2'd2; exp_data = 16'h0000;
        end else begin
            exp_data   = send_word;
            exp_status = (send_word == 16'h000D) ? 2'd1 : 2'd0;
            if (exp_status == 2'd0 && cmd == 4'd1) exp_pwr = 1'b1;
            if (exp_status == 2'd0 && cmd == 4'd0) exp_pwr = 1'b0;
        end

        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_data = wdata;
        rsp_ready = 1'b0; offer_ready = 1'b0; dfcq_ready = 1'b0; send_valid = 1'b0;
        step();
        req_valid = 1'b0; req_cmd = 4'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);

        cyc = 0; hs = 0; stalls = 0; wait_cyc = 0; in_wait = 1'b0; seen = 1'b0;
        addr_left = addr_hold; bad_idle = 0; bad_order = 0;
        while (cyc < 200) begin
            cyc++;
            send_valid = 1'b0; offer_ready = 1'b0; dfcq_ready = 1'b0; send = 16'($urandom);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (!offer_valid && offer !== 4'd0) bad_idle++;
            if (!dfcq_valid && receive !== 16'd0) bad_idle++;
            if (offer_valid) begin
                offer_ready = rnd_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (offer_ready) begin got_offers.push_back(offer); hs++; end
                else stalls++;
            end
            if (dfcq_valid) begin
                if (got_words.size() < exp_words.size()) begin
                    if (receive !== exp_words[got_words.size()]) bad_order++;
                end else begin
                    bad_order++;
                end
                if (addr_left > 0) begin
                    dfcq_ready = 1'b0;
                    addr_left--;
                end else begin
                    dfcq_ready = rnd_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (dfcq_ready) begin got_words.push_back(receive); hs++; end
                else stalls++;
            end
            if (in_wait) begin
                if (wait_cyc == send_delay) begin
                    send_valid = 1'b1;
                    send = send_word;
                end
                wait_cyc++;
            end else if (!local_rej && hs == 1 + exp_words.size()) begin
                in_wait = 1'b1;
            end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
                // Stray response while still on the link phase must be ignored.
                send_valid = 1'b1;
                send = 16'h000D;
            end
            step();
        end
        send_valid = 1'b0;

        if (local_rej)      exp_lat = 1;
        else if (timed_out) exp_lat = 1 + exp_words.size() + stalls + TO + 1;
        else                exp_lat = 1 + exp_words.size() + stalls + send_delay + 2;

        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s rsp_valid_bound: no response within 200 cycles", name);
        end
        checks++;
        if (cyc != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        checks++;
        if (rsp_status !== exp_status) begin
            failures++;
            $display("FAIL %s status: got %0d want %0d", name, rsp_status, exp_status);
        end
        checks++;
        if (rsp_data !== exp_data) begin
            failures++;
            $display("FAIL %s rsp_data: got %h want %h", name, rsp_data, exp_data);
        end
        checks++;
        if (powered !== exp_pwr) begin
            failures++;
            $display("FAIL %s powered: got %b want %b", name, powered, exp_pwr);
        end
        offers_ok = local_rej ? (got_offers.size() == 0)
                              : (got_offers.size() == 1 && got_offers[0] == cmd);
        checks++;
        if (!offers_ok) begin
            failures++;
            $display("FAIL %s offer_traffic: got %0d offers want %0d of cmd %0d",
                     name, got_offers.size(), local_rej ? 0 : 1, cmd);
        end
        words_ok = local_rej ? (got_words.size() == 0) : (got_words == exp_words);
        checks++;
        if (!words_ok || bad_order != 0) begin
            failures++;
            $display("FAIL %s receive_traffic: got %0d words (%0d wrong) want %0d",
                     name, got_words.size(), bad_order, local_rej ? 0 : exp_words.size());
        end
        checks++;
        if (bad_idle != 0) begin
            failures++;
            $display("FAIL %s idle_payload_zero: got %0d nonzero idle payload cycles want 0",
                     name, bad_idle);
        end

        // Response must be held while the host stalls.
        bad_hold = 0;
        for (int i = 0; i < rsp_hold; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_status !== exp_status)
                bad_hold++;
        end
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL %s rsp_hold: got %0d unstable cycles want 0", name, bad_hold);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (current_state !== 3'd0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s return_idle: got state %0d rsp_valid %b want 0 0",
                     name, current_state, rsp_valid);
        end
        model_powered = exp_pwr;
        txn_no++;
        $display("txn %0d %s cmd=%0d addr=%h data=%h status=%0d rsp=%h lat=%0d powered=%b",
                 txn_no, name, cmd, addr, wdata, rsp_status, rsp_data, cyc, powered);
    endtask

    task automatic test_reset;
        RESET = 1'b1; req_valid = 1'b1; req_cmd = 4'd1;
        offer_ready = 1'b1; dfcq_ready = 1'b1; send_valid = 1'b1; send = 16'h0001;
        step(); step();
        checks++;
        if (current_state !== 3'd0 || powered !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got state %0d powered %b want 0 0", current_state, powered);
        end
        checks++;
        if (rsp_valid !== 1'b0 || offer_valid !== 1'b0 || dfcq_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valids: got %b%b%b want 000", rsp_valid, offer_valid, dfcq_valid);
        end
        checks++;
        if (rsp_data !== 16'd0 || rsp_status !== 2'd0 || offer !== 4'd0 || receive !== 16'd0) begin
            failures++;
            $display("FAIL reset_payloads: got rsp %h st %0d offer %0d recv %h want all 0",
                     rsp_data, rsp_status, offer, receive);
        end
        RESET = 1'b0; req_valid = 1'b0; offer_ready = 1'b0; dfcq_ready = 1'b0; send_valid = 1'b0;
        model_powered = 1'b0;
        step();
        $display("txn reset done");
    endtask

    task automatic test_directed;
        do_txn(4'd2, 16'h0012, 16'h0000, 16'h5555, 0, 1'b0, 0, 0, "rd_unpowered");
        do_txn(4'd1, 16'h0000, 16'h0000, 16'h0001, 0, 1'b0, 0, 0, "pwr_on");
        do_txn(4'd3, 16'h0004, 16'hBEEF, 16'h0001, 0, 1'b0, 2, 2, "wr_addr_stall");
        do_txn(4'd2, 16'h0004, 16'h0000, 16'hBEEF, 0, 1'b0, 0, 0, "rd_ok");
        do_txn(4'd2, 16'h0033, 16'h0000, 16'h000D, 1, 1'b0, 0, 0, "rd_nak");
        do_txn(4'd7, 16'h0001, 16'h0002, 16'h0001, 0, 1'b0, 0, 1, "illegal_cmd");
        do_txn(4'd0, 16'h0000, 16'h0000, 16'h000D, 0, 1'b0, 0, 0, "pwr_off_nak");
    endtask

    // Long waits: timeout in the guarded build, plain long wait otherwise.
    task automatic test_timeout;
        do_txn(4'd2, 16'h0100, 16'h0000, 16'h1234, TO,     1'b0, 0, 0, "wait_past_limit");
        do_txn(4'd2, 16'h0101, 16'h0000, 16'h4321, TO - 1, 1'b0, 0, 0, "wait_expiry_cycle");
        do_txn(4'd3, 16'h0102, 16'h7777, 16'h0001, 20,     1'b0, 0, 0, "wait_long");
    endtask

    task automatic test_reset_mid;
        int bad;
        if (!model_powered)
            do_txn(4'd1, 16'h0000, 16'h0000, 16'h0001, 0, 1'b0, 0, 0, "pwr_on_pre");
        offer_ready = 1'b1; dfcq_ready = 1'b1;
        req_valid = 1'b1; req_cmd = 4'd3; req_addr = 16'h00AA; req_data = 16'hCAFE;
        step();
        req_valid = 1'b0;
        step(); step();
        checks++;
        if (current_state !== 3'd3) begin
            failures++;
            $display("FAIL reset_mid_reach_data: got state %0d want 3", current_state);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0; offer_ready = 1'b0; dfcq_ready = 1'b0;
        checks++;
        if (current_state !== 3'd0 || offer_valid !== 1'b0 || dfcq_valid !== 1'b0 ||
            rsp_valid !== 1'b0 || powered !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state: got st %0d ov %b dv %b rv %b pw %b want 0 0 0 0 0",
                     current_state, offer_valid, dfcq_valid, rsp_valid, powered);
        end
        model_powered = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            send_valid = 1'b1; send = 16'h0001;
            step();
            if (rsp_valid !== 1'b0) bad++;
        end
        send_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mid_no_rsp: got %0d response cycles want 0", bad);
        end
        $display("txn reset_mid done");
    endtask

    task automatic test_random;
        logic [3:0]  cmd;
        logic [15:0] sw;
        int          r, dly;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    cmd = 4'd1;
                2:       cmd = 4'd0;
                3, 4, 5: cmd = 4'd2;
                6, 7:    cmd = 4'd3;
                default: cmd = 4'($urandom_range(4, 15));
            endcase
            if ($urandom_range(0, 3) == 0)            sw = 16'h000D;
            else if (cmd == 4'd0 || cmd == 4'd1)      sw = 16'h0001;
            else                                      sw = 16'($urandom);
            dly = $urandom_range(0, 3);
            if (TO_EN && $urandom_range(0, 7) == 0) dly = TO + $urandom_range(0, 2);
            do_txn(cmd, 16'($urandom), 16'($urandom), sw, dly, 1'b1, 0,
                   $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        RESET = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_data = '0;
        rsp_ready = 1'b0; offer_ready = 1'b0; dfcq_ready = 1'b0;
        send = '0; send_valid = 1'b0;
        @(negedge CLK);
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
